// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: one state register, with every control output
// decoded combinationally from the state, opcode, ALU zero flag and mem_ready.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_reg;
    state_t state_next;

    assign state = state_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= FETCH;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal_op = 1'b0;

        case (state_reg)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_en      = mem_ready;
                state_next = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYP:      state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                state_next = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                iord       = 1'b1;
                state_next = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // Side-effecting strobes must stay quiet while reset is held, whatever the state.
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            pc_en      = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 One clock; reset is synchronous and active-low; ports clk, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 op  input  6  opcode field from instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory done; completes current access this cycle.
REQ-007 mem_req  output  1  memory access request, held until mem_ready.
REQ-008 mem_write  output  1  write qualifier for mem_req.
REQ-009 iord  output  1  address select: 0 = PC, 1 = ALU result register.
REQ-010 ir_write  output  1  instruction register load enable.
REQ-011 reg_dst  output  1  write register select: 0 = rt, 1 = rd.
REQ-012 mem_to_reg  output  1  writeback select: 0 = ALU result, 1 = memory data.
REQ-013 reg_write  output  1  register file write enable.
REQ-014 alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 alu_src_b  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-016 alu_op  output  2  ALU class to ALU decoder: 00 = add, 01 = sub, 10 = decode func field.
REQ-017 pc_src  output  2  PC source: 00 = ALU out, 01 = ALU result register, 10 = jump target.
REQ-018 pc_en  output  1  PC load enable.
REQ-019 illegal_op  output  1  pulse on unsupported opcode.
REQ-020 state  output  4  current state encoding, for debug.

Function
REQ-021 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11; codes 12-15 go to FETCH on the next edge.
REQ-022 Only state is registered; all outputs decode combinationally from state, op, zero and mem_ready.
REQ-023 Any output not listed for a state is 0.
REQ-024 FETCH outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
REQ-025 FETCH: ir_write=mem_ready, pc_en=mem_ready; stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-026 DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-027 DECODE next state by op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
REQ-028 DECODE, any other op: illegal_op=1 for that cycle only, next state FETCH.
REQ-029 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEMRD if op=100011, else MEMWR.
REQ-030 MEMRD: mem_req=1, iord=1; hold while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-031 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; go to FETCH.
REQ-032 MEMWR: mem_req=1, mem_write=1, iord=1; hold while mem_ready=0; go to FETCH when mem_ready=1.
REQ-033 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; go to ALUWB.
REQ-034 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; go to FETCH.
REQ-035 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; go to FETCH.
REQ-036 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; go to ADDIWB.
REQ-037 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
REQ-038 JUMP: pc_src=10, pc_en=1; go to FETCH.
REQ-039 Latency in cycles with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each mem_ready=0 cycle adds one cycle.
REQ-040 A mem_ready pulse in a state that is not FETCH, MEMRD or MEMWR is ignored.

Reset
REQ-041 On a rising edge with rst_n=0, state becomes FETCH, including in the middle of an instruction or a memory wait.
REQ-042 While rst_n=0: mem_req, mem_write, ir_write, reg_write, pc_en and illegal_op are forced to 0.
REQ-043 The first edge with rst_n=1 evaluates FETCH normally.

Verification
REQ-044 Reset release, then lw (op=100011) with mem_ready=1 throughout -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-045 sw with mem_ready=0 for 3 cycles in MEMWR -> state stays 5 for 4 cycles with mem_req=1 and mem_write=1; then returns to 0; reg_write never asserted.
REQ-046 beq with zero=1 -> pc_en=1 and pc_src=01 in state 8; beq with zero=0 -> pc_en=0 in state 8; both return to 0.
REQ-047 op=111111 in DECODE -> illegal_op=1 for exactly one cycle, next state 0, no reg_write.
REQ-048 rst_n driven low during MEMRD wait (mem_ready=0) -> mem_req=0 while low; state=0 after the edge; the next fetch proceeds normally.
REQ-049 Stall FETCH 2 cycles then mem_ready=1 -> ir_write=1 and pc_en=1 only in the mem_ready cycle; alu_src_b=01 throughout FETCH.
